bit_pattern_gen: RTL and testbench

//   Inverse of the bit-count unit: given a requested count N, serially builds a

---
 rtl/bit_pattern_gen.sv | 91 +++++++++
 tb/tb_bit_pattern_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bit_pattern_gen.sv
// bit_pattern_gen: serially builds a WIDTH-bit word holding exactly N ones,
// one bit per clock. The ones are packed at the LSB end (msb_first=0) or at
// the MSB end (msb_first=1). Requests with N > WIDTH are clipped to WIDTH and
// flagged on err.
module bit_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             msb_first,
    output logic [WIDTH-1:0] pattern,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] rem;     // ones still to be inserted
    logic [CNT_W-1:0] steps;   // shifts still to be performed
    logic             mode;    // msb_first captured at the accepted start
    logic             accept;  // start is honoured only outside SHIFT
    logic             bit_in;  // bit inserted on the current shift

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign bit_in = (rem != '0);

    // State register; sclr clears it without waiting for a clock edge.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge sclr) begin
        if (!sclr) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: start moves IDLE/DONE into SHIFT, the last shift ends in DONE.
    // NOTE: state_nxt is defaulted before the case so that every path assigns
    // it; a missing default would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)         state_nxt = SHIFT;
            SHIFT:   if (steps == ONE_C) state_nxt = DONE;
            DONE:    if (start)         state_nxt = SHIFT;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state, so busy and done are exclusive by construction.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath: latch the request on an accepted start, then shift one bit per clock.
    always_ff @(posedge clk or negedge sclr) begin
        if (!sclr) begin
            pattern <= '0;
            rem     <= '0;
            steps   <= '0;
            mode    <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            rem     <= (count > WIDTH_C) ? WIDTH_C : count;
            mode    <= msb_first;
            steps   <= WIDTH_C;
            pattern <= '0;
            err     <= (count > WIDTH_C);
        end else if (state == SHIFT) begin
            // The first bits inserted travel furthest, ending at bit 0 for
            // mode 0 (shift right) or at bit WIDTH-1 for mode 1 (shift left).
            if (mode) pattern <= {pattern[WIDTH-2:0], bit_in};
            else      pattern <= {bit_in, pattern[WIDTH-1:1]};
            if (bit_in) rem <= rem - ONE_C;
            steps <= steps - ONE_C;
        end
    end

endmodule

// File: tb/tb_bit_pattern_gen.sv
// Testbench for bit_pattern_gen: directed runs push their expected result
// into a queue; a monitor pops and compares on every rising edge of done.
module tb_bit_pattern_gen;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] pat;
        logic         err;
        int           ones;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         sclr;
    logic         start;
    logic [3:0]   count;
    logic         msb_first;
    logic [W-1:0] pattern;
    logic         busy;
    logic         done;
    logic         err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   busy_len = 0;
    logic done_q = 1'b0;
    exp_t q[$];

    bit_pattern_gen #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .start     (start),
        .count     (count),
        .msb_first (msb_first),
        .pattern   (pattern),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] exp_pat(input int n, input bit m);
        logic [W-1:0] p = '0;
        for (int i = 0; i < W; i++)
            if (i < n) begin
                if (m) p[W-1-i] = 1'b1;
                else   p[i]     = 1'b1;
            end
        return p;
    endfunction

    // Monitor: compare each completed run against the oldest expectation.
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pattern",  32'(pattern), 32'(e.pat));
                check("err",      32'(err),     32'(e.err));
                check("popcount", $countones(pattern), e.ones);
                check("done_cyc", cyc,          e.cyc);
                check("busy_len", busy_len,     W);
            end
        end
        if (done) check("busy_done_excl", 32'(busy), 32'd0);
        busy_len = busy ? busy_len + 1 : 0;
        done_q   = done;
    end

    // Drive start for one cycle from a negedge; optionally queue the expected result.
    task automatic issue(input int n, input bit m, input logic [W-1:0] p,
                         input logic e, input bit push);
        exp_t x;
        count     = 4'(n);
        msb_first = m;
        start     = 1'b1;
        if (push) begin
            x.pat  = p;
            x.err  = e;
            x.ones = (n > W) ? W : n;
            x.cyc  = cyc + 1 + W;
            q.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pattern"}, 32'(pattern), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
    endtask

    initial begin
        sclr      = 1'b0;
        start     = 1'b0;
        count     = '0;
        msb_first = 1'b0;
        wait_cycles(2);
        sclr = 1'b1;

        // Idle after reset with start low
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Basic runs, including back-to-back starts from DONE
        issue(3, 1'b0, 8'h07, 1'b0, 1'b1); wait_cycles(W + 2);
        issue(5, 1'b1, 8'hF8, 1'b0, 1'b1); wait_cycles(W);
        issue(0, 1'b0, 8'h00, 1'b0, 1'b1); wait_cycles(W);
        issue(8, 1'b0, 8'hFF, 1'b0, 1'b1); wait_cycles(W + 2);

        // Clipping and err clear
        issue(12, 1'b0, 8'hFF, 1'b1, 1'b1); wait_cycles(W);
        issue(2,  1'b0, 8'h03, 1'b0, 1'b1); wait_cycles(W + 2);

        // Inputs changed mid-SHIFT must be ignored
        issue(4, 1'b0, 8'h0F, 1'b0, 1'b1);
        start = 1'b1; count = 4'd7; msb_first = 1'b1;
        wait_cycles(3);
        start = 1'b0;
        wait_cycles(W + 2);

        // start held high: restart every W+1 cycles
        begin
            exp_t x;
            count = 4'd1; msb_first = 1'b0; start = 1'b1;
            for (int r = 0; r < 3; r++) begin
                x.pat = 8'h01; x.err = 1'b0; x.ones = 1;
                x.cyc = cyc + 1 + W + r * (W + 1);
                q.push_back(x);
            end
            wait_cycles(2 * (W + 1) + 1);
            start = 1'b0;
            wait_cycles(W + 2);
        end

        // Asynchronous reset in the middle of a clipped run
        issue(12, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_cycles(4);
        check("mid_pattern", 32'(pattern), 32'hF0);
        check("mid_err",     32'(err),     32'd1);
        check("mid_busy",    32'(busy),    32'd1);
        #2 sclr = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        sclr = 1'b1;
        wait_cycles(W + 2);
        check_idle("post_rst");

        // Every count in both modes
        for (int n = 0; n <= W; n++)
            for (int m = 0; m < 2; m++) begin
                issue(n, m[0], exp_pat(n, m[0]), 1'b0, 1'b1);
                wait_cycles(W);
            end
        wait_cycles(W + 2);

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
